box_field: RTL

BOX_FIELD -- requirements
Module: box_field

---
 rtl/box_field_if.sv | 40 ++++
 rtl/box_field.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/box_field_if.sv
// Bundle of pixel, bomberman, explosion and status signals between the
// game logic (master) and the box field (slave).
interface box_field_if #(
    parameter int NUM_BOXES = 8,
    parameter int TILE      = 16
);
    localparam int SW = (TILE > 1) ? $clog2(TILE) : 1;

    logic [9:0]             v_x;
    logic [9:0]             v_y;
    logic [9:0]             b_x;
    logic [9:0]             b_y;
    logic [9:0]             e_x;
    logic [9:0]             e_y;
    logic                   explosion_SCEN;
    logic                   restore;
    logic [NUM_BOXES*20-1:0] box_pos;

    logic                   box_on;
    logic [SW-1:0]          sprite_row;
    logic [SW-1:0]          sprite_col;
    logic [3:0]             bomberman_blocked;
    logic [NUM_BOXES-1:0]   boxes_alive;
    logic                   expl_busy;
    logic                   expl_done;
    logic [5:0]             destroyed_count;
    logic                   all_cleared;

    modport master (
        output v_x, v_y, b_x, b_y, e_x, e_y, explosion_SCEN, restore, box_pos,
        input  box_on, sprite_row, sprite_col, bomberman_blocked, boxes_alive,
               expl_busy, expl_done, destroyed_count, all_cleared
    );

    modport slave (
        input  v_x, v_y, b_x, b_y, e_x, e_y, explosion_SCEN, restore, box_pos,
        output box_on, sprite_row, sprite_col, bomberman_blocked, boxes_alive,
               expl_busy, expl_done, destroyed_count, all_cleared
    );
endinterface

// File: rtl/box_field.sv
// Destructible box field: per-pixel box rendering, bomberman collision
// flags, and a sequential explosion scan that clears boxes caught in a
// plus-shaped blast.
module box_field #(
    parameter int NUM_BOXES = 8,
    parameter int TILE      = 16,
    parameter int BLAST     = 3
) (
    input  logic        clk,
    input  logic        reset,
    box_field_if.slave  bus
);
    localparam int SW = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int IW = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;

    localparam logic signed [10:0] T_S   = 11'(TILE);
    localparam logic signed [10:0] ONE_S = 11'sd1;
    localparam logic signed [10:0] ARM_S = 11'(BLAST * TILE);
    localparam logic [IW-1:0]      LAST  = IW'(NUM_BOXES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    // Differences are taken in 11-bit signed so coordinates near 0 or
    // near 1023 never wrap into a false hit.
    function automatic logic signed [10:0] sdiff(input logic [9:0] a, input logic [9:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    logic [9:0] box_x [NUM_BOXES];
    logic [9:0] box_y [NUM_BOXES];

    for (genvar g = 0; g < NUM_BOXES; g++) begin : g_unpack
        assign box_x[g] = bus.box_pos[20*g +: 10];
        assign box_y[g] = bus.box_pos[20*g+10 +: 10];
    end

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [9:0]             ex_q, ex_d;
    logic [9:0]             ey_q, ey_d;
    logic                   pend_q, pend_d;
    logic [9:0]             pex_q, pex_d;
    logic [9:0]             pey_q, pey_d;
    logic [NUM_BOXES-1:0]   alive_q, alive_d;
    logic [5:0]             count_q, count_d;

    logic                   box_on_q, box_on_d;
    logic [SW-1:0]          row_q, row_d;
    logic [SW-1:0]          col_q, col_d;
    logic [3:0]             blk_q, blk_d;

    logic                   blast_hit;

    // Pixel hit test; scanning from the top index down lets the lowest
    // index win on overlap.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        box_on_d = 1'b0;
        row_d    = '0;
        col_d    = '0;
        dx       = '0;
        dy       = '0;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            dx = sdiff(bus.v_x, box_x[i]);
            dy = sdiff(bus.v_y, box_y[i]);
            if (alive_q[i] && dx >= 0 && dx < T_S && dy >= 0 && dy < T_S) begin
                box_on_d = 1'b1;
                row_d    = dy[SW-1:0];
                col_d    = dx[SW-1:0];
            end
        end
    end

    // Collision flags: a 1-pixel step overlaps a box when the shifted
    // offset lies strictly inside (-TILE, TILE) on both axes.
    always_comb begin
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        logic               in_x;
        logic               in_y;
        blk_d = 4'b0000;
        dx    = '0;
        dy    = '0;
        in_x  = 1'b0;
        in_y  = 1'b0;
        for (int i = 0; i < NUM_BOXES; i++) begin
            dx   = sdiff(bus.b_x, box_x[i]);
            dy   = sdiff(bus.b_y, box_y[i]);
            in_x = (dx > -T_S) && (dx < T_S);
            in_y = (dy > -T_S) && (dy < T_S);
            if (alive_q[i]) begin
                // Bounds are rearranged so dx+1 / dy+1 are never formed.
                if (in_y && dx > (ONE_S - T_S) && dx <= T_S) blk_d[0] = 1'b1;
                if (in_y && dx >= -T_S && dx < (T_S - ONE_S)) blk_d[1] = 1'b1;
                if (in_x && dy > (ONE_S - T_S) && dy <= T_S) blk_d[2] = 1'b1;
                if (in_x && dy >= -T_S && dy < (T_S - ONE_S)) blk_d[3] = 1'b1;
            end
        end
    end

    // Plus-shaped blast test for the box currently indexed by the scan.
    always_comb begin
        logic signed [10:0] bdx;
        logic signed [10:0] bdy;
        bdx       = sdiff(box_x[idx_q], ex_q);
        bdy       = sdiff(box_y[idx_q], ey_q);
        blast_hit = ((bdy > -T_S) && (bdy < T_S) && (bdx >= -ARM_S) && (bdx <= ARM_S)) ||
                    ((bdx > -T_S) && (bdx < T_S) && (bdy >= -ARM_S) && (bdy <= ARM_S));
    end

    // Explosion FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Explosion FSM next state; restore overrides everything.
    always_comb begin
        state_d = state_q;
        if (bus.restore) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.explosion_SCEN) state_d = S_SCAN;
                S_SCAN:  if (idx_q == LAST) state_d = S_DONE;
                S_DONE:  state_d = (pend_q || bus.explosion_SCEN) ? S_SCAN : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Scan datapath: box index, blast centre, one-deep pending request,
    // alive mask and destroyed counter.
    always_comb begin
        idx_d   = idx_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        pend_d  = pend_q;
        pex_d   = pex_q;
        pey_d   = pey_q;
        alive_d = alive_q;
        count_d = count_q;
        if (bus.restore) begin
            idx_d   = '0;
            pend_d  = 1'b0;
            alive_d = '1;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.explosion_SCEN) begin
                        ex_d  = bus.e_x;
                        ey_d  = bus.e_y;
                        idx_d = '0;
                    end
                end
                S_SCAN: begin
                    // Only a live box is counted, so dead boxes never add to the tally.
                    if (alive_q[idx_q] && blast_hit) begin
                        alive_d[idx_q] = 1'b0;
                        if (count_q != 6'd63) count_d = count_q + 6'd1;
                    end
                    if (idx_q != LAST) idx_d = idx_q + IW'(1);
                    if (bus.explosion_SCEN && !pend_q) begin
                        pend_d = 1'b1;
                        pex_d  = bus.e_x;
                        pey_d  = bus.e_y;
                    end
                end
                S_DONE: begin
                    idx_d = '0;
                    // A queued request wins; a new one arriving now is dropped.
                    if (pend_q) begin
                        ex_d   = pex_q;
                        ey_d   = pey_q;
                        pend_d = 1'b0;
                    end else if (bus.explosion_SCEN) begin
                        ex_d = bus.e_x;
                        ey_d = bus.e_y;
                    end
                end
                default: idx_d = '0;
            endcase
        end
    end

    // Scan datapath registers; reset brings every box back to life.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
            pend_q  <= 1'b0;
            pex_q   <= '0;
            pey_q   <= '0;
            alive_q <= '1;
            count_q <= '0;
        end else begin
            idx_q   <= idx_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            pend_q  <= pend_d;
            pex_q   <= pex_d;
            pey_q   <= pey_d;
            alive_q <= alive_d;
            count_q <= count_d;
        end
    end

    // Pixel and collision outputs, registered for one cycle of latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            box_on_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            blk_q    <= 4'b0000;
        end else begin
            box_on_q <= box_on_d;
            row_q    <= row_d;
            col_q    <= col_d;
            blk_q    <= blk_d;
        end
    end

    // Explosion FSM outputs decoded from the state.
    always_comb begin
        bus.expl_busy = (state_q != S_IDLE);
        bus.expl_done = (state_q == S_DONE);
    end

    assign bus.box_on            = box_on_q;
    assign bus.sprite_row        = row_q;
    assign bus.sprite_col        = col_q;
    assign bus.bomberman_blocked = blk_q;
    assign bus.boxes_alive       = alive_q;
    assign bus.destroyed_count   = count_q;
    assign bus.all_cleared       = ~|alive_q;
endmodule
